cmd_frame_tx: RTL and testbench

Command-frame transmitter: the sending end of the 8-byte control-center command protocol. On a one-cycle `send` request it builds the frame EB 90 SRC DEST CODE CHK 09 D7 and pushes it byte-by-byte into the UART transmit FIFO via `tf_push`/`tdr`. It obeys FIFO occupancy, aborts with `err` after a full-FIFO timeout, and reports completion on `done`. It sits between the board supervisory logic and the UART TX FIFO, mirroring the command receiver on the far end of the link.

---
 rtl/cmd_frame_tx_if.sv | 33 +++
 rtl/cmd_frame_tx.sv | 169 ++++++++++++++++
 tb/tb_cmd_frame_tx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : cmd_frame_tx_if
// Brief    : Supervisor/TX-FIFO side signals of the command-frame transmitter.
// Revision : 1.0
// ============================================================================
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

interface cmd_frame_tx_if;
   logic                              send;
   logic [7:0]                        dest;
   logic [7:0]                        code;
   logic [`UART_FIFO_COUNTER_W-1:0]   tf_counter;
   logic                              tf_push;
   logic [7:0]                        tdr;
   logic                              busy;
   logic                              done;
   logic                              err;

   modport master (
      output send, dest, code, tf_counter,
      input  tf_push, tdr, busy, done, err
   );

   modport slave (
      input  send, dest, code, tf_counter,
      output tf_push, tdr, busy, done, err
   );
endinterface

`default_nettype wire

// File: rtl/cmd_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : cmd_frame_tx
// Brief    : Builds EB 90 SRC DEST CODE CHK 09 D7 and pushes it into the TX FIFO.
// Revision : 1.0
// ============================================================================
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

module cmd_frame_tx #(
   parameter logic [7:0] SRC_ID     = 8'h5A,
   parameter int         FIFO_DEPTH = 16,
   parameter int         PUSH_GAP   = 2,
   parameter int         TO_CYCLES  = 640
) (
   input  logic          clk,
   input  logic          rst_n,
   cmd_frame_tx_if.slave bus
);

   localparam int c_cnt_w = `UART_FIFO_COUNTER_W;
   localparam int c_to_w  = $clog2(TO_CYCLES + 1);
   localparam int c_gap_w = (PUSH_GAP > 1) ? $clog2(PUSH_GAP) : 1;

   localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(FIFO_DEPTH);
   localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TO_CYCLES - 1);
   localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((PUSH_GAP > 0) ? PUSH_GAP - 1 : 0);
   localparam logic [3:0]         c_last_idx = 4'd8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PUSH = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               r_state,   w_state_nxt;
   logic [3:0]           r_idx,     w_idx_nxt;
   logic [c_to_w-1:0]    r_to_cnt,  w_to_cnt_nxt;
   logic [c_gap_w-1:0]   r_gap_cnt, w_gap_cnt_nxt;
   logic [7:0]           r_dest,    w_dest_nxt;
   logic [7:0]           r_code,    w_code_nxt;
   logic [7:0]           r_chk,     w_chk_nxt;
   logic                 r_push,    w_push_nxt;
   logic [7:0]           r_tdr,     w_tdr_nxt;
   logic                 r_busy,    w_busy_nxt;
   logic                 r_done,    w_done_nxt;
   logic                 r_err,     w_err_nxt;

   logic [7:0]           w_byte;
   logic                 w_space;
   logic [7:0]           w_chk_new;

   assign w_space   = (bus.tf_counter < c_depth);
   // Negated sum so that SRC+DEST+CODE+CHK wraps to zero.
   assign w_chk_new = 8'h00 - (SRC_ID + bus.dest + bus.code);

   always_comb begin
      w_byte = 8'h00;
      case (r_idx)
         4'd0:    w_byte = 8'hEB;
         4'd1:    w_byte = 8'h90;
         4'd2:    w_byte = SRC_ID;
         4'd3:    w_byte = r_dest;
         4'd4:    w_byte = r_code;
         4'd5:    w_byte = r_chk;
         4'd6:    w_byte = 8'h09;
         4'd7:    w_byte = 8'hD7;
         default: w_byte = 8'h00;
      endcase
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_to_cnt_nxt  = r_to_cnt;
      w_gap_cnt_nxt = r_gap_cnt;
      w_dest_nxt    = r_dest;
      w_code_nxt    = r_code;
      w_chk_nxt     = r_chk;
      w_push_nxt    = 1'b0;
      w_tdr_nxt     = r_tdr;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      // Busy trails the state by one cycle so the done/err cycle still rejects send.
      w_busy_nxt    = (r_state != S_IDLE);

      unique case (r_state)
         S_IDLE: begin
            if (bus.send && !r_busy) begin
               w_dest_nxt   = bus.dest;
               w_code_nxt   = bus.code;
               w_chk_nxt    = w_chk_new;
               w_idx_nxt    = 4'd0;
               w_to_cnt_nxt = '0;
               w_busy_nxt   = 1'b1;
               w_state_nxt  = S_PUSH;
            end
         end
         S_PUSH: begin
            if (w_space) begin
               w_push_nxt    = 1'b1;
               w_tdr_nxt     = w_byte;
               w_idx_nxt     = r_idx + 4'd1;
               w_to_cnt_nxt  = '0;
               w_gap_cnt_nxt = '0;
               w_state_nxt   = S_GAP;
            end else if (r_to_cnt == c_to_last) begin
               w_err_nxt    = 1'b1;
               w_to_cnt_nxt = '0;
               w_state_nxt  = S_IDLE;
            end else begin
               w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
         end
         S_GAP: begin
            w_gap_cnt_nxt = r_gap_cnt + 1'b1;
            if (r_gap_cnt == c_gap_last) begin
               w_state_nxt = (r_idx == c_last_idx) ? S_DONE : S_PUSH;
            end
         end
         S_DONE: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_idx     <= 4'd0;
         r_to_cnt  <= '0;
         r_gap_cnt <= '0;
         r_dest    <= 8'h00;
         r_code    <= 8'h00;
         r_chk     <= 8'h00;
         r_push    <= 1'b0;
         r_tdr     <= 8'h00;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_to_cnt  <= w_to_cnt_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
         r_dest    <= w_dest_nxt;
         r_code    <= w_code_nxt;
         r_chk     <= w_chk_nxt;
         r_push    <= w_push_nxt;
         r_tdr     <= w_tdr_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign bus.tf_push = r_push;
   assign bus.tdr     = r_tdr;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cmd_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_frame_tx
// Brief    : Directed + random frames checked against a frame-level model.
// Revision : 1.0
// ============================================================================
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

module tb_cmd_frame_tx;

   localparam logic [7:0] SRC       = 8'h5A;
   localparam int         DEPTH     = 16;
   localparam int         GAP       = 2;
   localparam int         TO        = 640;
   localparam int         SPACING   = GAP + 1;
   localparam int         DONE_LAT  = 8 * SPACING + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   int   total = 0;
   int   bad   = 0;

   logic [7:0] push_q[$];
   int         push_t[$];
   int         n_done = 0;
   int         n_err  = 0;
   int         done_t = 0;
   int         err_t  = 0;
   int         n_consec = 0;
   logic       prev_push = 1'b0;
   int         send_edge = 0;

   cmd_frame_tx_if bus ();

   cmd_frame_tx #(
      .SRC_ID     (SRC),
      .FIFO_DEPTH (DEPTH),
      .PUSH_GAP   (GAP),
      .TO_CYCLES  (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.tf_push === 1'b1) begin
         push_q.push_back(bus.tdr);
         push_t.push_back(cyc);
      end
      if (bus.done === 1'b1) begin
         n_done++;
         done_t = cyc;
      end
      if (bus.err === 1'b1) begin
         n_err++;
         err_t = cyc;
      end
      if (bus.tf_push === 1'b1 && prev_push === 1'b1) n_consec++;
      prev_push = bus.tf_push;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checksum from the protocol rule: the four payload bytes sum to zero mod 256.
   function automatic logic [7:0] model_chk(input logic [7:0] d, input logic [7:0] c);
      int s;
      s = (int'(SRC) + int'(d) + int'(c)) % 256;
      return 8'((256 - s) % 256);
   endfunction

   task automatic clear_mon();
      push_q.delete();
      push_t.delete();
      n_done = 0;
      n_err  = 0;
   endtask

   task automatic do_send(input logic [7:0] d, input logic [7:0] c);
      clear_mon();
      bus.dest  = d;
      bus.code  = c;
      bus.send  = 1'b1;
      send_edge = cyc + 1;
      step();
      bus.send  = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int budget);
      int n = 0;
      while (((n_done + n_err) == 0 || bus.busy !== 1'b0) && n < budget) begin
         step();
         n++;
      end
      check({tag, " end_in_time"}, 32'(n < budget), 1);
   endtask

   task automatic wait_pushes(input string tag, input int cnt, input int budget);
      int n = 0;
      while (push_q.size() < cnt && n < budget) begin
         step();
         n++;
      end
      check({tag, " pushes_in_time"}, 32'(n < budget), 1);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] d, input logic [7:0] c,
                              input bit timed);
      logic [7:0] exp [8];
      logic [7:0] obs;
      int         sum;
      int         spacing_ok;
      exp = '{8'hEB, 8'h90, SRC, d, c, model_chk(d, c), 8'h09, 8'hD7};
      check({tag, " count"}, push_q.size(), 8);
      sum = 0;
      for (int i = 0; i < 8; i++) begin
         obs = (i < push_q.size()) ? push_q[i] : 8'hxx;
         if (i >= 2 && i <= 5) sum = sum + int'(obs);
         check($sformatf("%s byte%0d", tag, i), {24'h0, obs}, {24'h0, exp[i]});
      end
      check({tag, " payload_sum"}, sum % 256, 0);
      check({tag, " done_cnt"}, n_done, 1);
      check({tag, " err_cnt"}, n_err, 0);
      if (timed && push_t.size() == 8) begin
         spacing_ok = 1;
         for (int i = 0; i < 7; i++)
            if (push_t[i+1] - push_t[i] != SPACING) spacing_ok = 0;
         check({tag, " first_push_lat"}, push_t[0] - send_edge, 1);
         check({tag, " spacing"}, spacing_ok, 1);
         check({tag, " done_lat"}, done_t - send_edge, DONE_LAT);
      end
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] c;
      int         rel_edge;

      bus.send       = 1'b0;
      bus.dest       = 8'h00;
      bus.code       = 8'h00;
      bus.tf_counter = '0;
      rst_n          = 1'b0;
      repeat (3) step();
      check("reset outputs", {20'h0, bus.tf_push, bus.tdr, bus.busy, bus.done, bus.err}, 0);
      rst_n = 1'b1;
      step();

      // Basic frame
      do_send(8'hAB, 8'h0A);
      check("basic busy_after_send", {31'h0, bus.busy}, 1);
      wait_end("basic", 60);
      check_frame("basic", 8'hAB, 8'h0A, 1'b1);
      check("basic chk_value", {24'h0, push_q[5]}, 32'hF1);

      // Checksum wrap cases, sent back-to-back at the earliest legal edge
      do_send(8'h00, 8'h00);
      wait_end("wrapA6", 60);
      check_frame("wrapA6", 8'h00, 8'h00, 1'b1);
      do_send(8'hFF, 8'hA7);
      wait_end("wrap00", 60);
      check_frame("wrap00", 8'hFF, 8'hA7, 1'b1);

      // Random frames; inputs scrambled after acceptance must not leak in
      for (int k = 0; k < 6; k++) begin
         d = 8'($urandom);
         c = 8'($urandom);
         do_send(d, c);
         bus.dest = 8'($urandom);
         bus.code = 8'($urandom);
         wait_end($sformatf("rand%0d", k), 60);
         check_frame($sformatf("rand%0d", k), d, c, 1'b1);
      end

      // Back-pressure after the third push
      do_send(8'hAB, 8'h0A);
      wait_pushes("bp", 3, 40);
      bus.tf_counter = `UART_FIFO_COUNTER_W'(DEPTH);
      repeat (100) step();
      check("bp stalled_pushes", push_q.size(), 3);
      bus.tf_counter = `UART_FIFO_COUNTER_W'(DEPTH - 1);
      rel_edge = cyc + 1;
      wait_end("bp", 80);
      check_frame("bp", 8'hAB, 8'h0A, 1'b0);
      check("bp resume_edge", (push_t.size() > 3) ? push_t[3] : -1, rel_edge);
      bus.tf_counter = '0;
      step();

      // Timeout with FIFO full from the start
      bus.tf_counter = `UART_FIFO_COUNTER_W'(DEPTH);
      do_send(8'h12, 8'h34);
      wait_end("to", TO + 40);
      check("to err_cnt", n_err, 1);
      check("to done_cnt", n_done, 0);
      check("to pushes", push_q.size(), 0);
      check("to err_lat", err_t - send_edge, TO);
      bus.tf_counter = '0;
      repeat (5) step();
      check("to busy_after", {31'h0, bus.busy}, 0);
      check("to err_single", n_err, 1);
      d = 8'($urandom);
      c = 8'($urandom);
      do_send(d, c);
      wait_end("to_next", 60);
      check_frame("to_next", d, c, 1'b1);

      // Busy rejection: send mid-frame and in the done cycle
      do_send(8'hAB, 8'h33);
      repeat (10) step();
      bus.dest = 8'h11;
      bus.send = 1'b1;
      step();
      bus.send = 1'b0;
      while (cyc < send_edge + DONE_LAT) step();
      check("rej done_now", {31'h0, bus.done}, 1);
      bus.dest = 8'h11;
      bus.send = 1'b1;
      step();
      bus.send = 1'b0;
      repeat (40) step();
      check_frame("rej", 8'hAB, 8'h33, 1'b1);

      // Reset mid-frame after the fourth push
      do_send(8'hC3, 8'h5E);
      wait_pushes("rst", 4, 40);
      rst_n = 1'b0;
      step();
      check("rst outputs", {20'h0, bus.tf_push, bus.tdr, bus.busy, bus.done, bus.err}, 0);
      rst_n = 1'b1;
      repeat (30) step();
      check("rst no_done", n_done, 0);
      check("rst no_err", n_err, 0);
      check("rst pushes_frozen", push_q.size(), 4);
      d = 8'($urandom);
      c = 8'($urandom);
      do_send(d, c);
      wait_end("rst_next", 60);
      check_frame("rst_next", d, c, 1'b1);

      check("no_back_to_back_push", n_consec, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
